// File: rtl/rca_cfg_loader.sv
// -----------------------------------------------------------------------------
// rca_cfg_loader
//
// Reconfigures the RCA grid when issue control switches to a different
// accelerator. It waits for the grid to drain, then streams the selected
// accelerator's configuration words out of the config memory and into the
// grid configuration registers. When the last word is written it reports
// the loaded accelerator back to issue control.
//
// Optional feature (compile-time macro RCA_CFG_SKIP_RELOAD_EN):
//   When defined, a request for the accelerator that is already loaded and
//   valid completes immediately. No reads or writes are issued, load_done
//   pulses the cycle after acceptance and loaded_valid stays high.
//   When undefined, every accepted request performs a full drain and load.
//
// Parameters:
//   NUM_RCAS   number of accelerators with stored configurations (power of 2)
//   CFG_WORDS  configuration words per accelerator (power of 2)
//   CFG_WIDTH  bits per configuration word
//
// Ports:
//   clk           clock, all state updates on the rising edge
//   rst           asynchronous reset, active low
//   req_valid     request to load the configuration for req_rca_sel
//   req_rca_sel   target accelerator, sampled only at acceptance
//   req_ready     loader is idle and accepts a request this cycle
//   grid_idle     grid pipeline and IO FIFOs are empty
//   cfg_rd_en     config memory read strobe
//   cfg_rd_addr   config memory address = target*CFG_WORDS + rd_idx
//   cfg_rd_data   config memory read data, valid one cycle after cfg_rd_en
//   cfg_wr_en     grid config register write strobe
//   cfg_wr_addr   grid config register index
//   cfg_wr_data   write data, a combinational pass-through of cfg_rd_data
//   load_done     one-cycle pulse in the cycle the last word is written
//   loaded_valid  the grid holds a complete configuration
//   loaded_rca    accelerator currently configured
//   busy          loader is not idle
// -----------------------------------------------------------------------------
module rca_cfg_loader #(
   parameter int NUM_RCAS  = 4,
   parameter int CFG_WORDS = 16,
   parameter int CFG_WIDTH = 32
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  req_valid,
   input  logic [$clog2(NUM_RCAS)-1:0]           req_rca_sel,
   output logic                                  req_ready,
   input  logic                                  grid_idle,
   output logic                                  cfg_rd_en,
   output logic [$clog2(NUM_RCAS*CFG_WORDS)-1:0] cfg_rd_addr,
   input  logic [CFG_WIDTH-1:0]                  cfg_rd_data,
   output logic                                  cfg_wr_en,
   output logic [$clog2(CFG_WORDS)-1:0]          cfg_wr_addr,
   output logic [CFG_WIDTH-1:0]                  cfg_wr_data,
   output logic                                  load_done,
   output logic                                  loaded_valid,
   output logic [$clog2(NUM_RCAS)-1:0]           loaded_rca,
   output logic                                  busy
);

   localparam int SEL_W = $clog2(NUM_RCAS);
   localparam int IDX_W = $clog2(CFG_WORDS);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CFG_WORDS - 1);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      WAIT_DRAIN = 2'd1,
      LOAD       = 2'd2,
      FLUSH      = 2'd3
   } state_t;

   state_t            state;
   logic [SEL_W-1:0]  target;
   logic [IDX_W-1:0]  rd_idx;

   // Both sizes are powers of two, so target*CFG_WORDS + rd_idx is a plain
   // concatenation of the two fields.
   assign cfg_rd_addr = {target, rd_idx};

   // Read data is consumed directly as write data; the one-cycle memory
   // latency is absorbed by delaying the write strobe and index instead.
   assign cfg_wr_data = cfg_rd_data;

   assign req_ready = (state == IDLE);
   assign busy      = (state != IDLE);

   // NOTE: every register here uses non-blocking assignment so all state
   // advances together on the edge, and the async reset clears the strobes
   // immediately without waiting for a clock.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         target       <= '0;
         rd_idx       <= '0;
         cfg_rd_en    <= 1'b0;
         cfg_wr_en    <= 1'b0;
         cfg_wr_addr  <= '0;
         load_done    <= 1'b0;
         loaded_valid <= 1'b0;
         loaded_rca   <= '0;
      end else begin
         // Write pipeline: the word read in cycle k lands on the grid in
         // cycle k+1, so the write strobe and index trail the read by one.
         cfg_wr_en   <= cfg_rd_en;
         cfg_wr_addr <= rd_idx;
         load_done   <= 1'b0;

         case (state)
            IDLE: begin
               if (req_valid) begin
                  target <= req_rca_sel;
`ifdef RCA_CFG_SKIP_RELOAD_EN
                  if (loaded_valid && (req_rca_sel == loaded_rca)) begin
                     // Already configured: go straight to completion with
                     // no traffic; FLUSH writes nothing because no read
                     // preceded it, and loaded_valid is left untouched.
                     state     <= FLUSH;
                     load_done <= 1'b1;
                  end else begin
                     state        <= WAIT_DRAIN;
                     loaded_valid <= 1'b0;
                  end
`else
                  state        <= WAIT_DRAIN;
                  loaded_valid <= 1'b0;
`endif
               end
            end

            WAIT_DRAIN: begin
               // Unbounded wait: the grid must be empty before any of its
               // configuration registers may be overwritten.
               if (grid_idle) begin
                  state     <= LOAD;
                  rd_idx    <= '0;
                  cfg_rd_en <= 1'b1;
               end
            end

            LOAD: begin
               // rd_idx wraps to zero after the last word; its value outside
               // LOAD is never used.
               rd_idx <= rd_idx + 1'b1;
               if (rd_idx == LAST_IDX) begin
                  state     <= FLUSH;
                  cfg_rd_en <= 1'b0;
                  // Raised here so the pulse coincides with the final write.
                  load_done <= 1'b1;
               end
            end

            FLUSH: begin
               state        <= IDLE;
               loaded_valid <= 1'b1;
               loaded_rca   <= target;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rca_cfg_loader.sv
// -----------------------------------------------------------------------------
// tb_rca_cfg_loader
//
// Self-checking bench for rca_cfg_loader with default parameters
// (4 accelerators, 16 words of 32 bits). A behavioural config memory with
// one-cycle read latency feeds the DUT, and a grid register array records
// every write. Expected traffic for each load is derived from the request's
// accept cycle and drain length with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_rca_cfg_loader;

   localparam int NR = 4;
   localparam int CW = 16;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic [1:0]  req_rca_sel;
   logic        req_ready;
   logic        grid_idle;
   logic        cfg_rd_en;
   logic [5:0]  cfg_rd_addr;
   logic [31:0] cfg_rd_data;
   logic        cfg_wr_en;
   logic [3:0]  cfg_wr_addr;
   logic [31:0] cfg_wr_data;
   logic        load_done;
   logic        loaded_valid;
   logic [1:0]  loaded_rca;
   logic        busy;

   rca_cfg_loader #(
      .NUM_RCAS  (NR),
      .CFG_WORDS (CW),
      .CFG_WIDTH (32)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_rca_sel  (req_rca_sel),
      .req_ready    (req_ready),
      .grid_idle    (grid_idle),
      .cfg_rd_en    (cfg_rd_en),
      .cfg_rd_addr  (cfg_rd_addr),
      .cfg_rd_data  (cfg_rd_data),
      .cfg_wr_en    (cfg_wr_en),
      .cfg_wr_addr  (cfg_wr_addr),
      .cfg_wr_data  (cfg_wr_data),
      .load_done    (load_done),
      .loaded_valid (loaded_valid),
      .loaded_rca   (loaded_rca),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Config memory: one-cycle read latency, output holds between reads.
   logic [31:0] mem  [NR*CW];
   logic [31:0] grid [CW];

   always @(posedge clk) begin
      if (cfg_rd_en) cfg_rd_data <= mem[cfg_rd_addr];
   end

   int errs   = 0;
   int checks = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [47:0] pack(input logic rd, input logic [5:0] ra, input logic wr,
                                        input logic [3:0] wa, input logic [31:0] wd, input logic dn,
                                        input logic bz, input logic rdy, input logic lv);
      return {rd, ra, wr, wa, wd, dn, bz, rdy, lv};
   endfunction

   // Issue one load starting at a negedge; returns at the negedge of the
   // load_done cycle. Every cycle of the load is compared against the
   // expected read/write/status pattern.
   task automatic run_load(input int sel, input int drain, input bit keep_valid, input int next_sel,
                           output int lat, output int first_rd, output int last_rd, output int nreads);
      int nwrites;
      int good;
      bit exp_rd, exp_wr, exp_dn;
      int ridx, widx;
      logic [47:0] act, exp;
      lat = 0; first_rd = -1; last_rd = -1; nreads = 0; nwrites = 0;
      for (int i = 0; i < CW; i++) grid[i] = ~mem[sel*CW + i];
      check($sformatf("req_ready_before_sel%0d", sel), req_ready, 1);
      req_valid   = 1'b1;
      req_rca_sel = 2'(sel);
      grid_idle   = (drain == 0);
      @(posedge clk);
      for (int n = 1; n <= 200; n++) begin
         @(negedge clk);
         if (cfg_wr_en) begin
            grid[cfg_wr_addr] = cfg_wr_data;
            nwrites++;
         end
         if (cfg_rd_en) begin
            if (nreads == 0) first_rd = int'(cfg_rd_addr);
            last_rd = int'(cfg_rd_addr);
            nreads++;
         end
         ridx   = n - drain - 2;
         widx   = n - drain - 3;
         exp_rd = (ridx >= 0) && (ridx < CW);
         exp_wr = (widx >= 0) && (widx < CW);
         exp_dn = (n == drain + CW + 2);
         exp = pack(exp_rd, exp_rd ? 6'(sel*CW + ridx) : 6'd0,
                    exp_wr, exp_wr ? 4'(widx) : 4'd0,
                    exp_wr ? mem[sel*CW + widx] : 32'd0,
                    exp_dn, 1'b1, 1'b0, 1'b0);
         act = pack(cfg_rd_en, exp_rd ? cfg_rd_addr : 6'd0,
                    cfg_wr_en, exp_wr ? cfg_wr_addr : 4'd0,
                    exp_wr ? cfg_wr_data : 32'd0,
                    load_done, busy, req_ready, loaded_valid);
         check($sformatf("sel%0d_cyc%0d", sel, n), act, exp);
         if (load_done) begin
            lat = n;
            break;
         end
         if (n > drain + 1)      grid_idle = 1'($urandom);
         else if (n > drain)     grid_idle = 1'b1;
         else                    grid_idle = 1'b0;
         if (keep_valid) begin
            req_rca_sel = 2'(next_sel);
         end else begin
            req_valid   = 1'($urandom);
            req_rca_sel = 2'($urandom);
         end
      end
      if (lat == 0) check($sformatf("sel%0d_done_timeout", sel), 0, 1);
      if (!keep_valid) req_valid = 1'b0;
      check($sformatf("sel%0d_writes", sel), nwrites, CW);
      good = 0;
      for (int i = 0; i < CW; i++) if (grid[i] === mem[sel*CW + i]) good++;
      check($sformatf("sel%0d_grid_words", sel), good, CW);
   endtask

   // One cycle after load_done: idle with the new configuration reported.
   task automatic check_idle(input int sel);
      @(negedge clk);
      check($sformatf("idle_after_sel%0d", sel),
            {loaded_valid, loaded_rca, req_ready, busy, cfg_rd_en, cfg_wr_en, load_done},
            {1'b1, 2'(sel), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
   endtask

   typedef struct {
      int sel;
      int drain;
      bit keep;
      int next_sel;
      int exp_lat;
      int exp_first;
      int exp_last;
      int exp_reads;
   } vec_t;

   vec_t vecs [5];

   initial begin
      int lat, first_rd, last_rd, nreads;
      int sel, drain, last_sel, rd_cnt;
      bit have_loaded;

      // Basic load, drain wait, back-to-back pair, drain then wrap.
      vecs[0] = '{sel: 2, drain: 0, keep: 0, next_sel: 0, exp_lat: 18, exp_first: 32, exp_last: 47, exp_reads: 16};
      vecs[1] = '{sel: 1, drain: 5, keep: 0, next_sel: 0, exp_lat: 23, exp_first: 16, exp_last: 31, exp_reads: 16};
      vecs[2] = '{sel: 3, drain: 0, keep: 1, next_sel: 0, exp_lat: 18, exp_first: 48, exp_last: 63, exp_reads: 16};
      vecs[3] = '{sel: 0, drain: 0, keep: 0, next_sel: 0, exp_lat: 18, exp_first: 0,  exp_last: 15, exp_reads: 16};
      vecs[4] = '{sel: 3, drain: 2, keep: 0, next_sel: 0, exp_lat: 20, exp_first: 48, exp_last: 63, exp_reads: 16};

      for (int i = 0; i < NR*CW; i++) mem[i] = $urandom;
      cfg_rd_data = '0;
      rst         = 1'b0;
      req_valid   = 1'b0;
      req_rca_sel = '0;
      grid_idle   = 1'b0;

      #1;
      check("reset_outputs",
            {req_ready, busy, cfg_rd_en, cfg_wr_en, load_done, loaded_valid, loaded_rca},
            {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0});
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      for (int v = 0; v < 5; v++) begin
         run_load(vecs[v].sel, vecs[v].drain, vecs[v].keep, vecs[v].next_sel,
                  lat, first_rd, last_rd, nreads);
         check($sformatf("vec%0d_latency", v),   lat,      vecs[v].exp_lat);
         check($sformatf("vec%0d_first_rd", v),  first_rd, vecs[v].exp_first);
         check($sformatf("vec%0d_last_rd", v),   last_rd,  vecs[v].exp_last);
         check($sformatf("vec%0d_reads", v),     nreads,   vecs[v].exp_reads);
         check_idle(vecs[v].sel);
      end

      // Async reset after the 7th read of a load.
      req_valid   = 1'b1;
      req_rca_sel = 2'd1;
      grid_idle   = 1'b1;
      rd_cnt      = 0;
      @(posedge clk);
      for (int n = 1; n <= 8; n++) begin
         @(negedge clk);
         req_valid = 1'b0;
         if (cfg_rd_en) rd_cnt++;
      end
      check("rst_pre_reads", rd_cnt, 7);
      check("rst_pre_strobes", {cfg_rd_en, cfg_wr_en}, 2'b11);
      #2 rst = 1'b0;
      #1;
      check("rst_async_strobes", {cfg_rd_en, cfg_wr_en, load_done}, 3'b000);
      check("rst_async_state", {loaded_valid, busy, req_ready}, 3'b001);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("rst_release", {req_ready, busy, loaded_valid, cfg_rd_en, cfg_wr_en}, 5'b10000);

      // Load sel=2, then request sel=2 again.
      run_load(2, 0, 0, 0, lat, first_rd, last_rd, nreads);
      check("pre_skip_latency", lat, 18);
      check_idle(2);
`ifdef RCA_CFG_SKIP_RELOAD_EN
      rd_cnt = 0;
      check("skip_req_ready", req_ready, 1);
      req_valid   = 1'b1;
      req_rca_sel = 2'd2;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      rd_cnt += int'(cfg_rd_en) + int'(cfg_wr_en);
      check("skip_done_cycle", {load_done, busy, loaded_valid}, 3'b111);
      @(negedge clk);
      rd_cnt += int'(cfg_rd_en) + int'(cfg_wr_en);
      check("skip_after", {load_done, busy, loaded_valid, loaded_rca, req_ready}, {3'b001, 2'd2, 1'b1});
      check("skip_traffic", rd_cnt, 0);
`else
      run_load(2, 0, 0, 0, lat, first_rd, last_rd, nreads);
      check("reload_latency", lat, 18);
      check("reload_reads", nreads, CW);
      check("reload_first_rd", first_rd, 32);
      check_idle(2);
`endif
      have_loaded = 1'b1;
      last_sel    = 2;

      // Randomized loads against the arithmetic model.
      for (int r = 0; r < 8; r++) begin
         sel   = int'($urandom_range(NR - 1, 0));
         if (have_loaded && sel == last_sel) sel = (sel + 1) % NR;
         drain = int'($urandom_range(6, 0));
         run_load(sel, drain, 0, 0, lat, first_rd, last_rd, nreads);
         check($sformatf("rand%0d_latency", r),  lat,      drain + CW + 2);
         check($sformatf("rand%0d_first_rd", r), first_rd, sel*CW);
         check($sformatf("rand%0d_last_rd", r),  last_rd,  sel*CW + CW - 1);
         check($sformatf("rand%0d_reads", r),    nreads,   CW);
         check_idle(sel);
         last_sel = sel;
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
